alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID→EX producer for the 32-bit ALU interface: encodes RV32I opcode/funct3/funct7[5] into the 4-bit ALU op code and selects operands.
- Holds the result in an ID/EX pipeline register with a valid/ready handshake, stall, flush and illegal-instruction flagging.
- Sits between the decoder/register file and the ALU. Its outputs drive the ALU operand and op inputs directly.

Parameters:
- XLEN, 32, operand/immediate/PC width
- RD_W, 5, destination register index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- rs1_data  in  XLEN  register-file read 1
- rs2_data  in  XLEN  register-file read 2
- imm  in  XLEN  sign-extended immediate
- pc  in  XLEN  instruction address
- rd_in  in  RD_W  destination index
- flush  in  1  kill held/incoming instruction (branch taken, trap)
- ex_valid  out  1  EX holds a live instruction
- ex_ready  in  1  EX consumes this cycle
- alu_op  out  4  ALU op code
- data_one  out  XLEN  ALU operand 1
- data_two  out  XLEN  ALU operand 2
- rd_out  out  RD_W  destination index
- reg_write  out  1  writes rd
- is_branch  out  1  result is a branch compare (taken = ALU zero flag)
- illegal  out  1  unsupported encoding; valid alongside ex_valid

Behaviour:
- Op codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRA=6, SRL=7, OR=8, AND=9, BEQ=10, BNE=11, BLT=12, BGE=13. 14 and 15 are never issued.
- OP (0110011): funct3 maps add/sub(f7_5)/sll/slt/sltu/xor/srl-sra(f7_5)/or/and. Operands: rs1, rs2.
- OP-IMM (0010011): same mapping, except SUB is never produced (f7_5 is ignored for funct3=000). data_two = imm. Shift amount = imm[4:0], zero-extended.
- LOAD (0000011), STORE (0100011), JALR (1100111): ADD, rs1 + imm. STORE has reg_write=0.
- LUI (0110111): ADD, data_one = 0, data_two = imm.
- AUIPC (0010111): ADD, data_one = pc, data_two = imm.
- JAL (1101111): ADD, data_one = pc, data_two = imm.
- BRANCH (1100011): funct3 000/001/100/101 map to BEQ/BNE/BLT/BGE, operands rs1/rs2, is_branch=1, reg_write=0. BLTU/BGEU (110/111) are illegal.
- reg_write = 1 only when rd_in != 0 and the opcode writes rd.
- Illegal handling: any other opcode or funct combination gives illegal=1, alu_op=ADD, reg_write=0, is_branch=0. The instruction still issues.
- Register states:
  - EMPTY → FULL on in_valid & in_ready.
  - FULL → EMPTY on ex_ready with no new input.
  - FULL → FULL on a simultaneous consume and accept (back-to-back, no bubble).
- Latency: one cycle from acceptance to ex_valid.
- Outputs hold stable while ex_valid=1 & ex_ready=0.
- flush:
  - Clears ex_valid next cycle.
  - Discards any same-cycle input; in_ready is still reported, but nothing is captured.
  - flush has priority over all other events.
- Reset (rst_n=0 at an edge):
  - ex_valid=0, illegal=0, reg_write=0, is_branch=0, alu_op=0, data_one=0, data_two=0, rd_out=0.
  - An instruction in flight mid-reset is dropped.
  - in_ready=1 from the first cycle after reset deasserts.

Optional Feature:
- ALU_ISSUE_SKID_EN defined:
  - A second (skid) entry is added.
  - in_ready is a register equal to "skid empty", so there is no combinational path from ex_ready.
  - On stall, an accepted instruction parks in the skid entry and is presented immediately after the main entry drains.
  - flush clears both entries.
- Undefined: single entry, with in_ready = !ex_valid | ex_ready (combinational).

Decomposition:
- Shared package alu_pkg:
  - 4-bit op code constants (ADD..BGE)
  - RV32I opcode constants
  - funct3 constants
  - struct/typedef for the issue payload: alu_op, data_one, data_two, rd, reg_write, is_branch, illegal.
- Sub-module alu_op_encoder: purely combinational field → payload encoder. The top contains the pipeline/skid registers and handshake.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0, in_ready=1, ex_valid=0.
- OP-type, funct3=000, f7_5=1, rs1=10, rs2=3, rd=5 → next cycle ex_valid=1, alu_op=1, data_one=10, data_two=3, rd_out=5, reg_write=1.
- OP-IMM SRAI, imm=0x0000_0404 (f7_5 set) → alu_op=6, data_two=4. ADDI with rd=0 → reg_write=0.
- Branch funct3=100 → alu_op=12, is_branch=1. funct3=110 → illegal=1, alu_op=0.
- ex_ready=0 for 4 cycles while in_valid pulses twice → first payload stable. Without SKID: second instruction not accepted until drain. With SKID: second accepted, issued the cycle after the first drains, no bubble.
- flush asserted the same cycle as in_valid while FULL → next cycle ex_valid=0 and the incoming instruction is never issued.
- Back-to-back stream of 8 LUI/AUIPC/JAL with ex_ready=1 → one issue per cycle. AUIPC pc=0x100, imm=0x2000 → data_one=0x100, data_two=0x2000, alu_op=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU op codes, RV32I opcode and
// funct3 constants, the issue payload record and the op-mapping helper.
package alu_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALU_RD_W = 5;

  // 4-bit ALU op codes (14 and 15 are never issued)
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRA  = 4'd6,
    OP_SRL  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_BLT  = 4'd12,
    OP_BGE  = 4'd13
  } alu_op_e;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 values for OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct3 values for BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  // Everything the EX stage needs for one instruction
  typedef struct packed {
    alu_op_e               alu_op;
    logic [ALU_XLEN-1:0]   data_one;
    logic [ALU_XLEN-1:0]   data_two;
    logic [ALU_RD_W-1:0]   rd;
    logic                  reg_write;
    logic                  is_branch;
    logic                  illegal;
  } issue_t;

  // Map an OP/OP-IMM funct3 to an ALU op; alt selects SUB/SRA
  function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      F3_ADD_SUB: op = alt ? OP_SUB : OP_ADD;
      F3_SLL:     op = OP_SLL;
      F3_SLT:     op = OP_SLT;
      F3_SLTU:    op = OP_SLTU;
      F3_XOR:     op = OP_XOR;
      F3_SRL_SRA: op = alt ? OP_SRA : OP_SRL;
      F3_OR:      op = OP_OR;
      F3_AND:     op = OP_AND;
      default:    op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID/EX issue bus: the registered payload presented to the ALU plus its
// valid/ready handshake. The issue stage is the master, the ALU the slave.
interface alu_issue_stage_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) ();
  logic            ex_valid;
  logic            ex_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] data_one;
  logic [XLEN-1:0] data_two;
  logic [RD_W-1:0] rd_out;
  logic            reg_write;
  logic            is_branch;
  logic            illegal;

  modport master (
    output ex_valid, alu_op, data_one, data_two, rd_out, reg_write, is_branch, illegal,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, alu_op, data_one, data_two, rd_out, reg_write, is_branch, illegal,
    output ex_ready
  );
endinterface

// File: rtl/alu_op_encoder.sv
// Combinational RV32I field decoder: turns opcode/funct3/funct7[5] plus the
// register/immediate/pc values into one issue payload (op, operands, flags).
module alu_op_encoder
  import alu_pkg::*;
(
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  input  logic [ALU_XLEN-1:0] rs1_data,
  input  logic [ALU_XLEN-1:0] rs2_data,
  input  logic [ALU_XLEN-1:0] imm,
  input  logic [ALU_XLEN-1:0] pc,
  input  logic [ALU_RD_W-1:0] rd_in,
  output issue_t              payload
);

  alu_op_e             op;
  logic [ALU_XLEN-1:0] d1;
  logic [ALU_XLEN-1:0] d2;
  logic                writes_rd;
  logic                branch;
  logic                bad;

  // Decode the instruction class into op, operands and raw flags
  always_comb begin
    op        = OP_ADD;
    d1        = rs1_data;
    d2        = rs2_data;
    writes_rd = 1'b0;
    branch    = 1'b0;
    bad       = 1'b0;
    case (opcode)
      OPC_OP: begin
        op        = arith_op(funct3, funct7_5);
        writes_rd = 1'b1;
        // only ADD/SUB and SRL/SRA have an alternate form
        if (funct7_5 && (funct3 != F3_ADD_SUB) && (funct3 != F3_SRL_SRA)) begin
          bad = 1'b1;
        end else begin
          bad = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        // no SUBI: funct7[5] only distinguishes SRAI from SRLI
        op        = arith_op(funct3, funct7_5 && (funct3 == F3_SRL_SRA));
        writes_rd = 1'b1;
        if ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA)) begin
          d2 = {{(ALU_XLEN-5){1'b0}}, imm[4:0]};
        end else begin
          d2 = imm;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        d2        = imm;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        d2        = imm;
        writes_rd = 1'b0;
      end
      OPC_LUI: begin
        d1        = {ALU_XLEN{1'b0}};
        d2        = imm;
        writes_rd = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        d1        = pc;
        d2        = imm;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        branch = 1'b1;
        case (funct3)
          F3_BEQ:  op = OP_BEQ;
          F3_BNE:  op = OP_BNE;
          F3_BLT:  op = OP_BLT;
          F3_BGE:  op = OP_BGE;
          default: bad = 1'b1;
        endcase
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

  // Apply illegal override and the rd==x0 write suppression
  always_comb begin
    payload.data_one = d1;
    payload.data_two = d2;
    payload.rd       = rd_in;
    payload.illegal  = bad;
    if (bad) begin
      payload.alu_op    = OP_ADD;
      payload.reg_write = 1'b0;
      payload.is_branch = 1'b0;
    end else begin
      payload.alu_op    = op;
      payload.reg_write = writes_rd && (rd_in != {ALU_RD_W{1'b0}});
      payload.is_branch = branch;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: encodes the decoded instruction and holds it in the
// ID/EX register behind a valid/ready handshake with stall and flush.
// Build option ALU_ISSUE_SKID_EN adds a skid entry so in_ready is registered
// and has no combinational path from ex_ready.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int RD_W = ALU_RD_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [RD_W-1:0] rd_in,
  input  logic            flush,
  alu_issue_stage_if.master ex
);

  issue_t enc;
  issue_t main_q;
  logic   main_valid;

  alu_op_encoder u_encoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .pc       (pc),
    .rd_in    (rd_in),
    .payload  (enc)
  );

`ifdef ALU_ISSUE_SKID_EN
  issue_t skid_q;
  logic   skid_valid;
  logic   ready_q;
  issue_t main_d;
  issue_t skid_d;
  logic   main_valid_d;
  logic   skid_valid_d;
  logic   accept;

  assign in_ready = ready_q;
  assign accept   = in_valid && ready_q;

  // Next state for main/skid entries: flush wins, then drain, then park on stall
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid || ex.ex_ready) begin
      if (skid_valid) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_d       = enc;
        skid_valid_d = accept;
      end else if (accept) begin
        main_d       = enc;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      if (accept) begin
        skid_d       = enc;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid;
      end
    end
  end

  // Main and skid registers; in_ready tracks "skid will be empty"
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_valid <= 1'b0;
      skid_q     <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      main_q     <= main_d;
      main_valid <= main_valid_d;
      skid_q     <= skid_d;
      skid_valid <= skid_valid_d;
      ready_q    <= !skid_valid_d;
    end
  end
`else
  assign in_ready = !main_valid || ex.ex_ready;

  // Single ID/EX entry: flush wins, then accept (incl. back-to-back), then drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      main_q     <= enc;
      main_valid <= 1'b1;
    end else if (ex.ex_ready) begin
      main_valid <= 1'b0;
    end else begin
      main_valid <= main_valid;
    end
  end
`endif

  assign ex.ex_valid  = main_valid;
  assign ex.alu_op    = main_q.alu_op;
  assign ex.data_one  = main_q.data_one;
  assign ex.data_two  = main_q.data_two;
  assign ex.rd_out    = main_q.rd;
  assign ex.reg_write = main_q.reg_write;
  assign ex.is_branch = main_q.is_branch;
  assign ex.illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (default and skid builds).
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [4:0]  rd_in;
  logic        flush;

  int n_cmp = 0;
  int n_bad = 0;

  alu_issue_stage_if #(.XLEN(32), .RD_W(5)) bus ();

  alu_issue_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .pc       (pc),
    .rd_in    (rd_in),
    .flush    (flush),
    .ex       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] p, input logic [4:0] rd);
    in_valid = 1'b1;
    opcode   = op;
    funct3   = f3;
    funct7_5 = f7;
    rs1_data = a;
    rs2_data = b;
    imm      = im;
    pc       = p;
    rd_in    = rd;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; bus.ex_ready = 1'b1;
    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0; pc = 32'd0; rd_in = 5'd0;

    // reset for 3 cycles
    repeat (3) tick();
    rst_n = 1'b1;
    check_eq("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
    check_eq("rst_data_one", bus.data_one, 32'd0);
    check_eq("rst_data_two", bus.data_two, 32'd0);
    check_eq("rst_flags", {27'd0, bus.rd_out, bus.reg_write, bus.is_branch, bus.illegal}, 32'd0);

    // OP SUB rs1=10 rs2=3 rd=5
    drive(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0, 5'd5);
    tick();
    check_eq("sub_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_eq("sub_op", {28'd0, bus.alu_op}, 32'd1);
    check_eq("sub_d1", bus.data_one, 32'd10);
    check_eq("sub_d2", bus.data_two, 32'd3);
    check_eq("sub_rd", {27'd0, bus.rd_out}, 32'd5);
    check_eq("sub_rw", {31'd0, bus.reg_write}, 32'd1);

    // SRAI imm=0x404 -> shamt 4
    drive(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0404, 32'd0, 5'd6);
    tick();
    check_eq("srai_op", {28'd0, bus.alu_op}, 32'd6);
    check_eq("srai_d2", bus.data_two, 32'd4);

    // ADDI with rd=0 -> no write, f7_5 ignored
    drive(7'b0010011, 3'b000, 1'b1, 32'd1, 32'd0, 32'd7, 32'd0, 5'd0);
    tick();
    check_eq("addi_op", {28'd0, bus.alu_op}, 32'd0);
    check_eq("addi_d2", bus.data_two, 32'd7);
    check_eq("addi_rw", {31'd0, bus.reg_write}, 32'd0);

    // STORE: ADD rs1+imm, no write
    drive(7'b0100011, 3'b010, 1'b0, 32'h40, 32'h99, 32'h8, 32'd0, 5'd7);
    tick();
    check_eq("st_d1d2", bus.data_one + bus.data_two, 32'h48);
    check_eq("st_rw", {31'd0, bus.reg_write}, 32'd0);

    // BLT
    drive(7'b1100011, 3'b100, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd3);
    tick();
    check_eq("blt_op", {28'd0, bus.alu_op}, 32'd12);
    check_eq("blt_br", {30'd0, bus.is_branch, bus.reg_write}, 32'd2);
    check_eq("blt_ill", {31'd0, bus.illegal}, 32'd0);

    // BLTU is illegal but still issues
    drive(7'b1100011, 3'b110, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd3);
    tick();
    check_eq("bltu_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_eq("bltu_ill", {31'd0, bus.illegal}, 32'd1);
    check_eq("bltu_op", {28'd0, bus.alu_op}, 32'd0);
    check_eq("bltu_br", {30'd0, bus.is_branch, bus.reg_write}, 32'd0);

    // idle drains
    in_valid = 1'b0;
    tick();
    check_eq("idle_valid", {31'd0, bus.ex_valid}, 32'd0);

    // stall: I1 (ADD 1+2) held while I2 (XOR 5,6) pulses twice
    bus.ex_ready = 1'b0;
    drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd1);
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 0 || c == 2) drive(7'b0110011, 3'b100, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 5'd2);
      else in_valid = 1'b0;
      tick();
      check_eq("stall_valid", {31'd0, bus.ex_valid}, 32'd1);
      check_eq("stall_d1", bus.data_one, 32'd1);
      check_eq("stall_op", {28'd0, bus.alu_op}, 32'd0);
      check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    bus.ex_ready = 1'b1;
    tick();
`ifdef ALU_ISSUE_SKID_EN
    check_eq("skid_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_eq("skid_d1", bus.data_one, 32'd5);
    check_eq("skid_op", {28'd0, bus.alu_op}, 32'd5);
    tick();
`endif
    check_eq("drain_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("drain_in_ready", {31'd0, in_ready}, 32'd1);

    // flush while FULL with same-cycle input
    bus.ex_ready = 1'b0;
    drive(7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 5'd3);
    tick();
    check_eq("pre_flush_d2", bus.data_two, 32'h1234_5000);
    drive(7'b0110011, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd4);
    flush = 1'b1;
    tick();
    check_eq("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    bus.ex_ready = 1'b1;
    tick();
    check_eq("flush_dropped", {31'd0, bus.ex_valid}, 32'd0);

    // back-to-back LUI/AUIPC/JAL stream
    for (int i = 0; i < 8; i++) begin
      logic [31:0] p;
      logic [31:0] im;
      logic [31:0] exp_d1;
      p  = 32'h0FC + 32'd4 * i;
      im = 32'h1000 * (i + 1);
      case (i % 3)
        0:       begin drive(7'b0110111, 3'b000, 1'b0, 32'hDEAD, 32'd0, im, p, 5'(i)); exp_d1 = 32'd0; end
        1:       begin drive(7'b0010111, 3'b000, 1'b0, 32'hDEAD, 32'd0, im, p, 5'(i)); exp_d1 = p; end
        default: begin drive(7'b1101111, 3'b000, 1'b0, 32'hDEAD, 32'd0, im, p, 5'(i)); exp_d1 = p; end
      endcase
      tick();
      check_eq("b2b_valid", {31'd0, bus.ex_valid}, 32'd1);
      check_eq("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("b2b_op", {28'd0, bus.alu_op}, 32'd0);
      check_eq("b2b_d1", bus.data_one, exp_d1);
      check_eq("b2b_d2", bus.data_two, im);
      check_eq("b2b_rd", {27'd0, bus.rd_out}, i);
      check_eq("b2b_rw", {31'd0, bus.reg_write}, (i != 0) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check_eq("end_valid", {31'd0, bus.ex_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
